sprite_renderer: RTL and testbench

//  Consumer side of the sprite_t interface: takes the sprite array driven by the game logic,

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_renderer_hit_test.sv | 25 ++
 rtl/sprite_renderer.sv | 166 ++++++++++++++++
 tb/tb_sprite_renderer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Purpose : Shared screen geometry, sprite description and separator constants
//           for the game-state logic and the sprite renderer.
// Contents: screen/position widths, sprite_t, separator placement, ball index.
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int unsigned SCREEN_H_RES = 640;
    localparam int unsigned SCREEN_V_RES = 480;
    localparam int unsigned X_POS_W      = 10;
    localparam int unsigned Y_POS_W      = 10;

    localparam int unsigned N_SPRITES    = 3;

    localparam int unsigned SEPARATOR_WIDTH      = 6;
    localparam int unsigned SEPARATOR_DOT_HEIGHT = 18;

    // Dashed centre line columns, right edge exclusive
    localparam int unsigned SEP_LEFT  = SCREEN_H_RES / 2 - SEPARATOR_WIDTH / 2;
    localparam int unsigned SEP_RIGHT = SEP_LEFT + SEPARATOR_WIDTH;

    // The ball is the last sprite; all lower indices are paddles
    localparam int unsigned DEFAULT_BALL_IDX = N_SPRITES - 1;

    // Axis-aligned box; right/bottom are exclusive
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

endpackage

// File: rtl/sprite_renderer_hit_test.sv
// -----------------------------------------------------------------------------
// sprite_hit_test
// Purpose : Combinational test of one scan position against one sprite box.
// Ports   : spr_i      sprite box (right/bottom exclusive)
//           x_pos_i    scan column
//           y_pos_i    scan row
//           visible_i  scan position is in the active area
//           hit_o      position lies inside the box and is visible
// -----------------------------------------------------------------------------
module sprite_hit_test
    import sprite_pkg::*;
(
    input  sprite_t            spr_i,
    input  logic [X_POS_W-1:0] x_pos_i,
    input  logic [Y_POS_W-1:0] y_pos_i,
    input  logic               visible_i,
    output logic               hit_o
);

    // An empty box (x_pos == right) can never satisfy both compares
    assign hit_o = visible_i
                 & (x_pos_i >= spr_i.x_pos) & (x_pos_i < spr_i.right)
                 & (y_pos_i >= spr_i.y_pos) & (y_pos_i < spr_i.bottom);

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
// Purpose : Snapshots the sprite array once per frame and converts the VGA scan
//           position into pixel decisions (sprite hits, dashed centre line).
//           Also reports which sprites the ball overlapped on screen per frame.
// Ports   : clk, rst          clock, async active-high reset
//           sprites_i         live sprite state from game logic
//           frame_start_i     1-cycle pulse per frame, in vertical blanking
//           visible_i, x_pos_i, y_pos_i   scan position
//           visible_o, sprite_hit_o, separator_o, pixel_on_o
//                             pixel decisions, 2 cycles after the scan input
//           overlap_o         ball/sprite overlap seen in the last frame
//           overlap_valid_o   1-cycle pulse when overlap_o updates
// -----------------------------------------------------------------------------
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPR    = N_SPRITES,
    parameter int unsigned BALL_IDX = N_SPR - 1,
    parameter bit          SEP_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  sprite_t            sprites_i [N_SPR],
    input  logic               frame_start_i,
    input  logic               visible_i,
    input  logic [X_POS_W-1:0] x_pos_i,
    input  logic [Y_POS_W-1:0] y_pos_i,
    output logic               visible_o,
    output logic [N_SPR-1:0]   sprite_hit_o,
    output logic               separator_o,
    output logic               pixel_on_o,
    output logic [N_SPR-1:0]   overlap_o,
    output logic               overlap_valid_o
);

    localparam int unsigned CNT_W = $clog2(SEPARATOR_DOT_HEIGHT);

    sprite_t            r_shadow [N_SPR];
    logic [N_SPR-1:0]   w_hit;
    logic [N_SPR-1:0]   r_s1_hit;
    logic               r_s1_sep;
    logic               r_s1_vis;
    logic               r_s1_fs;
    logic [N_SPR-1:0]   r_acc;
    logic [N_SPR-1:0]   w_contrib;

    logic [CNT_W-1:0]   r_line_cnt;
    logic               r_phase;
    logic               r_row_valid;
    logic [Y_POS_W-1:0] r_last_y;
    logic               w_new_row;
    logic               w_wrap;
    logic               w_phase;
    logic               w_sep;

    // Shadow is only read by the hit tests, so the image cannot tear mid-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SPR); i++) begin
                r_shadow[i] <= '0;
            end
        end else if (frame_start_i) begin
            r_shadow <= sprites_i;
        end
    end

    for (genvar g = 0; g < int'(N_SPR); g++) begin : g_hit
        sprite_hit_test u_hit (
            .spr_i     (r_shadow[g]),
            .x_pos_i   (x_pos_i),
            .y_pos_i   (y_pos_i),
            .visible_i (visible_i),
            .hit_o     (w_hit[g])
        );
    end

    // Dash line counter: the first visible row of a frame only records its
    // row number, later row changes advance the count.
    assign w_new_row = visible_i & r_row_valid & (y_pos_i != r_last_y);
    assign w_wrap    = w_new_row & (r_line_cnt == CNT_W'(SEPARATOR_DOT_HEIGHT - 1));
    // Use the phase of the row being entered, not the one just left
    assign w_phase   = w_wrap ? ~r_phase : r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_cnt  <= '0;
            r_phase     <= 1'b0;
            r_row_valid <= 1'b0;
            r_last_y    <= '0;
        end else if (frame_start_i) begin
            r_line_cnt  <= '0;
            r_phase     <= 1'b0;
            r_row_valid <= 1'b0;
        end else if (visible_i) begin
            r_row_valid <= 1'b1;
            r_last_y    <= y_pos_i;
            if (w_wrap) begin
                r_line_cnt <= '0;
                r_phase    <= ~r_phase;
            end else if (w_new_row) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

    assign w_sep = SEP_EN & visible_i & ~w_phase
                 & (x_pos_i >= X_POS_W'(SEP_LEFT)) & (x_pos_i < X_POS_W'(SEP_RIGHT));

    // Stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hit <= '0;
            r_s1_sep <= 1'b0;
            r_s1_vis <= 1'b0;
            r_s1_fs  <= 1'b0;
        end else begin
            r_s1_hit <= w_hit;
            r_s1_sep <= w_sep;
            r_s1_vis <= visible_i;
            r_s1_fs  <= frame_start_i;
        end
    end

    // Stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            visible_o    <= 1'b0;
            sprite_hit_o <= '0;
            separator_o  <= 1'b0;
            pixel_on_o   <= 1'b0;
        end else begin
            visible_o    <= r_s1_vis;
            sprite_hit_o <= r_s1_hit;
            separator_o  <= r_s1_sep;
            pixel_on_o   <= (|r_s1_hit) | r_s1_sep;
        end
    end

    always_comb begin
        w_contrib = '0;
        for (int i = 0; i < int'(N_SPR); i++) begin
            if (i != int'(BALL_IDX)) begin
                w_contrib[i] = r_s1_hit[BALL_IDX] & r_s1_hit[i];
            end
        end
    end

    // A pixel arriving with frame_start belongs to the new frame's accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc           <= '0;
            overlap_o       <= '0;
            overlap_valid_o <= 1'b0;
        end else begin
            overlap_valid_o <= r_s1_fs;
            if (r_s1_fs) begin
                overlap_o <= r_acc;
                r_acc     <= w_contrib;
            end else begin
                r_acc     <= r_acc | w_contrib;
            end
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
module tb_sprite_renderer;
    import sprite_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    sprite_t            spr [N_SPRITES];
    logic               fs;
    logic               vis;
    logic [X_POS_W-1:0] x;
    logic [Y_POS_W-1:0] y;

    logic                 visible_o, separator_o, pixel_on_o, overlap_valid_o;
    logic [N_SPRITES-1:0] sprite_hit_o, overlap_o;
    logic                 ns_visible_o, ns_separator_o, ns_pixel_on_o, ns_overlap_valid_o;
    logic [N_SPRITES-1:0] ns_sprite_hit_o, ns_overlap_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_renderer dut (
        .clk             (clk),
        .rst             (rst),
        .sprites_i       (spr),
        .frame_start_i   (fs),
        .visible_i       (vis),
        .x_pos_i         (x),
        .y_pos_i         (y),
        .visible_o       (visible_o),
        .sprite_hit_o    (sprite_hit_o),
        .separator_o     (separator_o),
        .pixel_on_o      (pixel_on_o),
        .overlap_o       (overlap_o),
        .overlap_valid_o (overlap_valid_o)
    );

    sprite_renderer #(.SEP_EN(1'b0)) dut_nosep (
        .clk             (clk),
        .rst             (rst),
        .sprites_i       (spr),
        .frame_start_i   (fs),
        .visible_i       (vis),
        .x_pos_i         (x),
        .y_pos_i         (y),
        .visible_o       (ns_visible_o),
        .sprite_hit_o    (ns_sprite_hit_o),
        .separator_o     (ns_separator_o),
        .pixel_on_o      (ns_pixel_on_o),
        .overlap_o       (ns_overlap_o),
        .overlap_valid_o (ns_overlap_valid_o)
    );

    function automatic sprite_t mk(input int a, input int b, input int c, input int d);
        sprite_t s;
        s.x_pos  = X_POS_W'(a);
        s.y_pos  = Y_POS_W'(b);
        s.right  = X_POS_W'(c);
        s.bottom = Y_POS_W'(d);
        return s;
    endfunction

    // Drive one scan cycle, then wait past the next rising edge
    task automatic step(input logic f, input logic v, input int xx, input int yy);
        fs  = f;
        vis = v;
        x   = X_POS_W'(xx);
        y   = Y_POS_W'(yy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N_SPRITES-1:0] exp_hit;
        rst = 1'b1;
        for (int i = 0; i < int'(N_SPRITES); i++) spr[i] = mk(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        spr[0] = mk(30, 215, 40, 265);
        step(1, 0, 0, 0);
        step(0, 1, 35, 215);
        step(0, 1, 35, 215);
        step(0, 1, 35, 215);
        checks++;
        if (sprite_hit_o !== 3'b001) begin
            errors++;
            $display("FAIL pre_reset_hit: got %b expected %b", sprite_hit_o, 3'b001);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({visible_o, sprite_hit_o, separator_o, pixel_on_o, overlap_o, overlap_valid_o}
            !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got vis=%b hit=%b sep=%b pix=%b ov=%b ovv=%b expected all 0",
                     visible_o, sprite_hit_o, separator_o, pixel_on_o, overlap_o, overlap_valid_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(0, 1, 35, 215);
        checks++;
        if (sprite_hit_o !== 3'b000 || visible_o !== 1'b1) begin
            errors++;
            $display("FAIL no_hit_before_frame: got hit=%b vis=%b expected hit=000 vis=1",
                     sprite_hit_o, visible_o);
        end
        step(1, 0, 0, 0);
        step(0, 1, 35, 215);
        checks++;
        if (overlap_valid_o !== 1'b1 || overlap_o !== 3'b000) begin
            errors++;
            $display("FAIL first_frame_overlap: got valid=%b ov=%b expected valid=1 ov=000",
                     overlap_valid_o, overlap_o);
        end
        step(0, 1, 35, 215);
        exp_hit = 3'b001;
        checks++;
        if (sprite_hit_o !== exp_hit) begin
            errors++;
            $display("FAIL hit_after_frame: got %b expected %b", sprite_hit_o, exp_hit);
        end
    endtask

    task automatic test_paddle();
        logic [N_SPRITES-1:0] exp_hit;
        int xp;
        for (int i = 0; i < 14; i++) begin
            step(0, (i < 12), 29 + i, 215);
            if (i >= 1 && i <= 12) begin
                xp = 29 + i - 1;
                exp_hit = (xp >= 30 && xp <= 39) ? 3'b001 : 3'b000;
                checks++;
                if (sprite_hit_o !== exp_hit || pixel_on_o !== exp_hit[0] || visible_o !== 1'b1)
                begin
                    errors++;
                    $display("FAIL paddle_x%0d: got hit=%b pix=%b vis=%b expected hit=%b pix=%b vis=1",
                             xp, sprite_hit_o, pixel_on_o, visible_o, exp_hit, exp_hit[0]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        spr[0] = mk(100, 215, 110, 265);
        step(0, 1, 35, 215);
        step(0, 1, 105, 215);
        checks++;
        if (sprite_hit_o !== 3'b001) begin
            errors++;
            $display("FAIL snap_old_pos_kept: got %b expected 001", sprite_hit_o);
        end
        step(0, 0, 0, 0);
        checks++;
        if (sprite_hit_o !== 3'b000) begin
            errors++;
            $display("FAIL snap_new_pos_hidden: got %b expected 000", sprite_hit_o);
        end
        step(1, 0, 0, 0);
        step(0, 1, 35, 215);
        step(0, 1, 105, 215);
        checks++;
        if (sprite_hit_o !== 3'b000) begin
            errors++;
            $display("FAIL snap_old_pos_gone: got %b expected 000", sprite_hit_o);
        end
        step(0, 0, 0, 0);
        checks++;
        if (sprite_hit_o !== 3'b001) begin
            errors++;
            $display("FAIL snap_new_pos_shown: got %b expected 001", sprite_hit_o);
        end
    endtask

    task automatic test_separator();
        int  px, py;
        bit  pv;
        logic exp_sep;
        pv = 0;
        px = 0;
        py = 0;
        step(1, 0, 0, 0);
        for (int row = 0; row < 60; row++) begin
            for (int xx = 314; xx <= 325; xx++) begin
                step(0, 1, xx, row);
                if (pv) begin
                    exp_sep = (px >= 317 && px <= 322 && ((py / 18) % 2 == 0));
                    checks++;
                    if (separator_o !== exp_sep || pixel_on_o !== exp_sep
                        || ns_separator_o !== 1'b0) begin
                        errors++;
                        $display("FAIL sep_x%0d_y%0d: got sep=%b pix=%b nosep=%b expected sep=%b pix=%b nosep=0",
                                 px, py, separator_o, pixel_on_o, ns_separator_o, exp_sep, exp_sep);
                    end
                end
                pv = 1;
                px = xx;
                py = row;
            end
        end
        step(0, 0, 0, 0);
        exp_sep = 1'b0;
        checks++;
        if (separator_o !== exp_sep) begin
            errors++;
            $display("FAIL sep_last: got %b expected %b", separator_o, exp_sep);
        end
    endtask

    task automatic test_overlap();
        int pulses;
        logic [N_SPRITES-1:0] cap;
        spr[0] = mk(30, 215, 40, 265);
        spr[1] = mk(0, 0, 0, 0);
        spr[2] = mk(35, 220, 45, 230);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int xx = 34; xx <= 38; xx++) step(0, 1, xx, 220);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        pulses = 0;
        cap = 'x;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            if (overlap_valid_o === 1'b1) begin
                pulses++;
                cap = overlap_o;
            end
        end
        checks++;
        if (pulses != 1 || cap !== 3'b001) begin
            errors++;
            $display("FAIL overlap_frame1: got pulses=%0d ov=%b expected pulses=1 ov=001",
                     pulses, cap);
        end
        checks++;
        if (overlap_o !== 3'b001) begin
            errors++;
            $display("FAIL overlap_hold: got %b expected 001", overlap_o);
        end
        // Ball alone: x=40 is outside the paddle (right edge exclusive)
        for (int xx = 40; xx <= 44; xx++) step(0, 1, xx, 220);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        pulses = 0;
        cap = 'x;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            if (overlap_valid_o === 1'b1) begin
                pulses++;
                cap = overlap_o;
            end
        end
        checks++;
        if (pulses != 1 || cap !== 3'b000) begin
            errors++;
            $display("FAIL overlap_frame2: got pulses=%0d ov=%b expected pulses=1 ov=000",
                     pulses, cap);
        end
    endtask

    task automatic test_coincident();
        spr[0] = mk(500, 100, 510, 110);
        spr[2] = mk(600, 100, 605, 105);
        step(1, 1, 36, 221);
        step(0, 0, 0, 0);
        checks++;
        if (sprite_hit_o !== 3'b101 || overlap_valid_o !== 1'b1 || overlap_o !== 3'b000) begin
            errors++;
            $display("FAIL coincident_pixel: got hit=%b valid=%b ov=%b expected hit=101 valid=1 ov=000",
                     sprite_hit_o, overlap_valid_o, overlap_o);
        end
        step(0, 1, 36, 221);
        checks++;
        if (overlap_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL coincident_pulse_len: got %b expected 0", overlap_valid_o);
        end
        step(0, 0, 0, 0);
        checks++;
        if (sprite_hit_o !== 3'b000) begin
            errors++;
            $display("FAIL coincident_new_shadow: got %b expected 000", sprite_hit_o);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (overlap_valid_o !== 1'b1 || overlap_o !== 3'b001) begin
            errors++;
            $display("FAIL coincident_counted_new: got valid=%b ov=%b expected valid=1 ov=001",
                     overlap_valid_o, overlap_o);
        end
    endtask

    initial begin
        fs  = 1'b0;
        vis = 1'b0;
        x   = '0;
        y   = '0;
        test_reset();
        test_paddle();
        test_snapshot();
        test_separator();
        test_overlap();
        test_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
